// File: rtl/aes_dma_pkg.sv
// Shared types and encodings for the AES round DMA sequencer.
package aes_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_PT,
        S_LD_RK,
        S_RND,
        S_ST,
        S_FINISH,
        S_ERROR
    } seq_state_t;

    localparam logic DMA_LOAD  = 1'b0;
    localparam logic DMA_STORE = 1'b1;
    localparam logic SRC_ROM   = 1'b0;
    localparam logic SRC_RAM   = 1'b1;

endpackage

// File: rtl/aes_round_dma_sequencer_dma_req_port.sv
// DMA request port: registered request fields, start pulse, done edge detect
// and the shared wait timeout counter.
module dma_req_port
    import aes_dma_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  req_mode,
    input  logic                  req_src,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  tmo_clr,
    input  logic                  tmo_en,
    input  logic                  dma_done,
    output logic                  dma_start,
    output logic                  dma_mode,
    output logic                  dma_src_sel,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  cmpl,
    output logic                  timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic          done_q;
    logic [TW-1:0] tmo_cnt;

    // Fields only change on a new request, so they stay put until completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_start   <= 1'b0;
            dma_mode    <= DMA_LOAD;
            dma_src_sel <= SRC_ROM;
            dma_addr    <= '0;
            dma_wdata   <= '0;
            done_q      <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            dma_start <= req;
            done_q    <= dma_done;
            if (req) begin
                dma_mode    <= req_mode;
                dma_src_sel <= req_src;
                dma_addr    <= req_addr;
                dma_wdata   <= req_wdata;
            end
            if (tmo_clr || !tmo_en) tmo_cnt <= '0;
            else                    tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Rising edge only: a sticky done level counts once.
    assign cmpl    = dma_done & ~done_q;
    assign timeout = tmo_en & ~tmo_clr & (tmo_cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/aes_round_dma_sequencer.sv
// Sequences one AES-128 encryption over the DMA port and the round engine.
module aes_round_dma_sequencer
    import aes_dma_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_ROUNDS = 10,
    parameter int PT_ADDR    = 0,
    parameter int RES_BASE   = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_start,
    output logic                  busy,
    output logic                  op_done,
    output logic                  op_err,
    output logic [DATA_WIDTH-1:0] ciphertext,
    output logic                  dma_start,
    output logic                  dma_mode,
    output logic                  dma_src_sel,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic [DATA_WIDTH-1:0] dma_wdata,
    input  logic                  dma_done,
    input  logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  rnd_start,
    output logic [3:0]            rnd_idx,
    output logic [DATA_WIDTH-1:0] rnd_state,
    output logic [DATA_WIDTH-1:0] rnd_key,
    input  logic                  rnd_done,
    input  logic [DATA_WIDTH-1:0] rnd_result,
    output logic [2:0]            dbg_state
);

    // Handshakes: dma_start/rnd_start pulse for one cycle on entry to the
    // waiting state; the request is complete on the rising edge of dma_done
    // (or on the rnd_done pulse), and only one request is ever outstanding.

    seq_state_t            fsm_q, fsm_nxt;
    logic [3:0]            round_q, round_nxt;
    logic [DATA_WIDTH-1:0] blk_q, blk_nxt, key_q, key_nxt, ct_q, ct_nxt;
    logic                  rnd_start_q, rnd_req;
    logic                  dma_req, req_mode, req_src;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  cmpl, timeout, waiting;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            round_q     <= '0;
            blk_q       <= '0;
            key_q       <= '0;
            ct_q        <= '0;
            rnd_start_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_nxt;
            round_q     <= round_nxt;
            blk_q       <= blk_nxt;
            key_q       <= key_nxt;
            ct_q        <= ct_nxt;
            rnd_start_q <= rnd_req;
        end
    end

    always_comb begin
        fsm_nxt   = fsm_q;
        round_nxt = round_q;
        blk_nxt   = blk_q;
        key_nxt   = key_q;
        ct_nxt    = ct_q;
        rnd_req   = 1'b0;
        dma_req   = 1'b0;
        req_mode  = DMA_LOAD;
        req_src   = SRC_ROM;
        req_addr  = '0;
        req_wdata = '0;
        case (fsm_q)
            S_IDLE: if (op_start) begin
                fsm_nxt   = S_LD_PT;
                round_nxt = '0;
                dma_req   = 1'b1;
                req_src   = SRC_RAM;
                req_addr  = ADDR_WIDTH'(PT_ADDR);
            end
            S_LD_PT: if (cmpl) begin
                blk_nxt  = dma_rdata;
                fsm_nxt  = S_LD_RK;
                dma_req  = 1'b1;
                req_addr = ADDR_WIDTH'(round_q);
            end else if (timeout) fsm_nxt = S_ERROR;
            S_LD_RK: if (cmpl) begin
                key_nxt = dma_rdata;
                fsm_nxt = S_RND;
                rnd_req = 1'b1;
            end else if (timeout) fsm_nxt = S_ERROR;
            S_RND: if (rnd_done) begin
                // The round result becomes the working state for the next round.
                blk_nxt   = rnd_result;
                fsm_nxt   = S_ST;
                dma_req   = 1'b1;
                req_mode  = DMA_STORE;
                req_src   = SRC_RAM;
                req_addr  = ADDR_WIDTH'(RES_BASE) + ADDR_WIDTH'(round_q);
                req_wdata = rnd_result;
            end else if (timeout) fsm_nxt = S_ERROR;
            S_ST: if (cmpl) begin
                if (round_q == 4'(NUM_ROUNDS)) begin
                    fsm_nxt = S_FINISH;
                    ct_nxt  = blk_q;
                end else begin
                    round_nxt = round_q + 4'd1;
                    fsm_nxt   = S_LD_RK;
                    dma_req   = 1'b1;
                    req_addr  = ADDR_WIDTH'(round_q + 4'd1);
                end
            end else if (timeout) fsm_nxt = S_ERROR;
            S_FINISH: fsm_nxt = S_IDLE;
            S_ERROR:  fsm_nxt = S_IDLE;
            default:  fsm_nxt = S_IDLE;
        endcase
    end

    assign waiting = (fsm_q == S_LD_PT) || (fsm_q == S_LD_RK) ||
                     (fsm_q == S_RND)   || (fsm_q == S_ST);

    dma_req_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) u_port (
        .clk        (clk),
        .rst        (rst),
        .req        (dma_req),
        .req_mode   (req_mode),
        .req_src    (req_src),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .tmo_clr    (dma_start | rnd_start_q),
        .tmo_en     (waiting),
        .dma_done   (dma_done),
        .dma_start  (dma_start),
        .dma_mode   (dma_mode),
        .dma_src_sel(dma_src_sel),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .cmpl       (cmpl),
        .timeout    (timeout)
    );

    assign busy       = (fsm_q != S_IDLE);
    assign op_done    = (fsm_q == S_FINISH);
    assign op_err     = (fsm_q == S_ERROR);
    assign ciphertext = ct_q;
    assign rnd_start  = rnd_start_q;
    assign rnd_idx    = round_q;
    assign rnd_state  = blk_q;
    assign rnd_key    = key_q;
    assign dbg_state  = fsm_q;

endmodule

// File: tb/tb_aes_round_dma_sequencer.sv
// Bench for aes_round_dma_sequencer: reactive DMA/round models and a
// request scoreboard checked against a plain AES-fold reference.
`timescale 1ns/1ps
module tb_aes_round_dma_sequencer;

    localparam int DW       = 128;
    localparam int AW       = 4;
    localparam int NR       = 10;
    localparam int PT_ADDR  = 0;
    localparam int RES_BASE = 1;
    localparam int TIMEOUT  = 64;
    localparam int RW       = 2 + AW + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          op_start = 1'b0;
    logic          busy, op_done, op_err;
    logic [DW-1:0] ciphertext;
    logic          dma_start, dma_mode, dma_src_sel;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_done = 1'b0;
    logic [DW-1:0] dma_rdata = '0;
    logic          rnd_start;
    logic [3:0]    rnd_idx;
    logic [DW-1:0] rnd_state, rnd_key;
    logic          rnd_done = 1'b0;
    logic [DW-1:0] rnd_result = '0;
    logic [2:0]    dbg_state;

    aes_round_dma_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ROUNDS(NR),
        .PT_ADDR(PT_ADDR), .RES_BASE(RES_BASE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .op_start(op_start), .busy(busy),
        .op_done(op_done), .op_err(op_err), .ciphertext(ciphertext),
        .dma_start(dma_start), .dma_mode(dma_mode), .dma_src_sel(dma_src_sel),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_done(dma_done),
        .dma_rdata(dma_rdata), .rnd_start(rnd_start), .rnd_idx(rnd_idx),
        .rnd_state(rnd_state), .rnd_key(rnd_key), .rnd_done(rnd_done),
        .rnd_result(rnd_result), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [RW-1:0] exp_q[$];
    logic [DW-1:0] exp_in  [NR+1];
    logic [DW-1:0] exp_res [NR+1];
    logic [DW-1:0] ram     [16];
    int            exp_total, req_n, rnd_n, done_cnt, cyc_now;
    int            hang_req = 0, hang_cyc = 0, err_cyc = 0;
    int            lat_lo = 3, lat_hi = 3;
    bit            sticky = 1'b0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] key_of(input int r);
        return DW'(r) * 128'h11;
    endfunction

    always @(posedge clk) cyc_now <= cyc_now + 1;
    always @(negedge clk) if (op_done) done_cnt++;

    // ---------------- DMA model ----------------
    int            d_cnt;
    bit            d_pend = 1'b0;
    logic          d_src;
    logic [AW-1:0] d_addr;
    logic [RW-1:0] obs;

    always @(negedge clk) begin
        if (rst) begin
            dma_done = 1'b0;
            d_pend   = 1'b0;
        end else begin
            if (!sticky) dma_done = 1'b0;
            if (dma_start) begin
                req_n++;
                obs = {dma_mode, dma_src_sel, dma_addr, dma_mode ? dma_wdata : {DW{1'b0}}};
                if (exp_q.size() == 0) check("dma_req_extra", req_n, exp_total);
                else                   check("dma_req", obs, exp_q.pop_front());
                if (dma_mode) ram[dma_addr] = dma_wdata;
                dma_done = 1'b0;
                d_src    = dma_src_sel;
                d_addr   = dma_addr;
                if (req_n == hang_req) hang_cyc = cyc_now;
                else begin
                    d_pend = 1'b1;
                    d_cnt  = $urandom_range(lat_hi, lat_lo);
                end
            end else if (d_pend) begin
                d_cnt--;
                if (d_cnt == 0) begin
                    d_pend    = 1'b0;
                    dma_done  = 1'b1;
                    dma_rdata = d_src ? ram[d_addr] : key_of(int'(d_addr));
                end
            end
        end
    end

    // ---------------- round engine model ----------------
    int            r_cnt;
    bit            r_pend = 1'b0;
    logic [DW-1:0] r_res;

    always @(negedge clk) begin
        if (rst) begin
            rnd_done = 1'b0;
            r_pend   = 1'b0;
        end else begin
            rnd_done = 1'b0;
            if (rnd_start) begin
                if (rnd_n > NR) check("rnd_extra", rnd_n, NR);
                else begin
                    check("rnd_idx", rnd_idx, rnd_n);
                    check("rnd_state", rnd_state, exp_in[rnd_n]);
                    check("rnd_key", rnd_key, key_of(rnd_n));
                    r_res = exp_in[rnd_n] ^ key_of(rnd_n) ^ DW'(rnd_n);
                end
                rnd_n++;
                r_pend = 1'b1;
                r_cnt  = $urandom_range(4, 1);
            end else if (r_pend) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    r_pend     = 1'b0;
                    rnd_done   = 1'b1;
                    rnd_result = r_res;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic prep(input logic [DW-1:0] pt);
        logic [DW-1:0] s;
        s = pt;
        ram[PT_ADDR] = pt;
        exp_q.delete();
        exp_q.push_back({1'b0, 1'b1, AW'(PT_ADDR), {DW{1'b0}}});
        for (int r = 0; r <= NR; r++) begin
            exp_in[r]  = s;
            s          = s ^ key_of(r) ^ DW'(r);
            exp_res[r] = s;
            ram[RES_BASE + r] = '0;
            exp_q.push_back({1'b0, 1'b0, AW'(r), {DW{1'b0}}});
            exp_q.push_back({1'b1, 1'b1, AW'(RES_BASE + r), s});
        end
        exp_total = exp_q.size();
        req_n = 0;
        rnd_n = 0;
    endtask

    task automatic run_op(input logic [DW-1:0] pt, input bit expect_err);
        int cyc, base;
        prep(pt);
        base = done_cnt;
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        cyc = 0;
        while (!op_done && !op_err && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 4000) check("op_wait_bound", cyc, 0);
        else if (expect_err) begin
            check("op_err_pulse", op_err, 1);
            err_cyc = cyc_now;
        end else begin
            check("op_done_pulse", op_done, 1);
            check("ciphertext", ciphertext, exp_res[NR]);
            for (int r = 0; r <= NR; r++) check("ram_round_result", ram[RES_BASE + r], exp_res[r]);
            check("dma_req_count", req_n, exp_total);
            check("rnd_count", rnd_n, NR + 1);
        end
        @(negedge clk);
        check("busy_after", busy, 0);
        if (!expect_err) begin
            check("op_done_count", done_cnt - base, 1);
            repeat (3) @(negedge clk);
            check("ciphertext_hold", ciphertext, exp_res[NR]);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {busy, op_done, op_err, dma_start, dma_mode, dma_src_sel,
                               dma_addr, rnd_start, rnd_idx}, 0);
        check({tag, "_ciphertext"}, ciphertext, 0);
        check({tag, "_dma_wdata"}, dma_wdata, 0);
        check({tag, "_rnd_state"}, rnd_state, 0);
        check({tag, "_rnd_key"}, rnd_key, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] pt;
        int w;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // fixed 3-cycle DMA, zero plaintext
        run_op('0, 1'b0);

        // random plaintext and latencies, pulsed done
        lat_lo = 3; lat_hi = 7;
        repeat (3) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            run_op(pt, 1'b0);
        end

        // sticky done level
        sticky = 1'b1;
        repeat (2) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            run_op(pt, 1'b0);
        end
        sticky = 1'b0;
        repeat (2) @(negedge clk);

        // DMA stalls on the 5th request
        hang_req = 5;
        run_op({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        check("timeout_latency_in_window",
              (err_cyc - hang_cyc >= TIMEOUT) && (err_cyc - hang_cyc <= TIMEOUT + 2), 1);
        hang_req = 0;
        repeat (2) @(negedge clk);
        run_op({$urandom, $urandom, $urandom, $urandom}, 1'b0);

        // second op_start during round 4 is ignored
        pt = {$urandom, $urandom, $urandom, $urandom};
        fork
            run_op(pt, 1'b0);
            begin
                w = 0;
                while (!(rnd_start && rnd_idx == 4'd4) && w < 4000) begin
                    @(negedge clk);
                    w++;
                end
                check("round4_seen", w < 4000, 1);
                op_start = 1'b1;
                @(negedge clk);
                op_start = 1'b0;
            end
        join

        // reset in the middle of round 6
        prep({$urandom, $urandom, $urandom, $urandom});
        op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        w = 0;
        while (!(rnd_start && rnd_idx == 4'd6) && w < 4000) begin
            @(negedge clk);
            w++;
        end
        check("round6_seen", w < 4000, 1);
        #2 rst = 1'b1;
        #1 check_outputs_zero("midrun_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_op({$urandom, $urandom, $urandom, $urandom}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
